// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle controller for an external W-bit ripple add/sub unit.
// One pass of the adder for ADD/SUB/NEG. MUL_IT passes of unsigned shift-add for MUL.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, op, x, y       request; sampled only in idle; op 00 ADD, 01 SUB, 10 MUL, 11 NEG
//   busy, done            busy from accept through the done pulse; done is a one-cycle pulse
//   result, cout, ovf     registered result/flags, held until the next operation completes
//   add_x, add_y, add_sel drive the external adder (add_sel = 1 subtracts)
//   add_out, add_cout,    combinational sum and flags returned by the adder
//   add_ovf
module alu_op_sequencer #(
  parameter int unsigned W      = 6,
  parameter int unsigned MUL_IT = W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           cout,
  output logic           ovf,
  output logic [W-1:0]   add_x,
  output logic [W-1:0]   add_y,
  output logic           add_sel,
  input  logic [W-1:0]   add_out,
  input  logic           add_cout,
  input  logic           add_ovf
);

  localparam int unsigned IterW = $clog2(MUL_IT + 1);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpNeg = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic [W-1:0]       p_hi_q, p_hi_d;
  logic [W-1:0]       p_lo_q, p_lo_d;
  logic               c_q, c_d;
  logic [IterW-1:0]   iter_q, iter_d;
  logic [2*W-1:0]     result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    c_d      = c_q;
    iter_d   = iter_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    add_x    = '0;
    add_y    = '0;
    add_sel  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d  = x;
          b_d  = y;
          op_d = op;
          if (op == OpMul) begin
            p_hi_d  = '0;
            p_lo_d  = y;
            c_d     = 1'b0;
            iter_d  = '0;
            state_d = StMul;
          end else begin
            state_d = StExec;
          end
        end
      end

      StExec: begin
        unique case (op_q)
          OpSub: begin
            add_x   = a_q;
            add_y   = b_q;
            add_sel = 1'b1;
          end
          OpNeg: begin
            add_x   = '0;
            add_y   = b_q;
            add_sel = 1'b1;
          end
          default: begin
            add_x   = a_q;
            add_y   = b_q;
            add_sel = 1'b0;
          end
        endcase
        result_d = {{W{1'b0}}, add_out};
        cout_d   = add_cout;
        ovf_d    = add_ovf;
        state_d  = StDone;
      end

      StMul: begin
        // Add A into the high half when the current multiplier bit is set, then shift the
        // whole {carry, P_hi, P_lo} right by one so the carry lands in P_hi's MSB.
        add_x = p_hi_q;
        add_y = p_lo_q[0] ? a_q : '0;
        {c_d, p_hi_d, p_lo_d} = {add_cout, add_out, p_lo_q} >> 1;
        iter_d = iter_q + 1'b1;
        if (iter_q == IterW'(MUL_IT - 1)) begin
          result_d = {p_hi_d, p_lo_d};
          cout_d   = 1'b0;
          ovf_d    = |p_hi_d;
          state_d  = StDone;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      c_q      <= 1'b0;
      iter_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      c_q      <= c_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
